// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with rise/fall strobes usable as clock enables.
// Divisor changes and stop requests only take effect at period boundaries.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             ref_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             clk_fall,
    output logic [CNT_W-1:0] div_active,
    output logic             running,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

    typedef enum logic [0:0] {StParked, StRun} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_pend;
    logic             pend;

    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   h_cur;
    logic             wrap;

    always_comb begin
        // Divisor that governs a period starting on this edge.
        n_next  = pend ? div_pend : div_active;
        cnt_inc = cnt + 1'b1;
        // Extra bit keeps N+1 from overflowing at the maximum divisor.
        h_cur   = ({1'b0, div_active} + 1'b1) >> 1;
        wrap    = (cnt == div_active - 1'b1);
    end

    always_ff @(posedge ref_clock or posedge reset) begin
        if (reset) begin
            state      <= StParked;
            cnt        <= DefDiv - 1'b1;
            div_active <= DefDiv;
            div_pend   <= DefDiv;
            pend       <= 1'b0;
            clk_out    <= 1'b0;
            clk_rise   <= 1'b0;
            clk_fall   <= 1'b0;
            running    <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            clk_rise <= 1'b0;
            clk_fall <= 1'b0;
            div_err  <= 1'b0;
            case (state)
                StParked: begin
                    div_active <= n_next;
                    pend       <= 1'b0;
                    if (enable) begin
                        state    <= StRun;
                        running  <= 1'b1;
                        cnt      <= '0;
                        clk_out  <= 1'b1;
                        clk_rise <= 1'b1;
                    end else begin
                        cnt     <= n_next - 1'b1;
                        clk_out <= 1'b0;
                    end
                end
                StRun: begin
                    if (wrap) begin
                        div_active <= n_next;
                        pend       <= 1'b0;
                        if (enable) begin
                            cnt      <= '0;
                            clk_out  <= 1'b1;
                            clk_rise <= 1'b1;
                        end else begin
                            // Park instead of starting a new period.
                            state   <= StParked;
                            running <= 1'b0;
                            cnt     <= n_next - 1'b1;
                            clk_out <= 1'b0;
                        end
                    end else begin
                        cnt      <= cnt_inc;
                        clk_out  <= ({1'b0, cnt_inc} < h_cur);
                        clk_fall <= ({1'b0, cnt_inc} == h_cur);
                    end
                end
                default: state <= StParked;
            endcase
            // Loads land after the boundary logic so a coinciding load waits a period.
            if (div_load) begin
                if (div_in >= MinDiv) begin
                    div_pend <= div_in;
                    pend     <= 1'b1;
                end else begin
                    div_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: period-level waveform model checked every cycle,
// plus directed scenarios with hand-computed run lengths and strobe spacing.
module tb_clk_div_prog;

    logic       ref_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       div_load;
    logic [7:0] div_in;
    logic       clk_out, clk_rise, clk_fall, running, div_err;
    logic [7:0] div_active;

    int n_checks = 0;
    int n_pass   = 0;

    clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(10)) dut (
        .ref_clock  (ref_clock),
        .reset      (reset),
        .enable     (enable),
        .div_load   (div_load),
        .div_in     (div_in),
        .clk_out    (clk_out),
        .clk_rise   (clk_rise),
        .clk_fall   (clk_fall),
        .div_active (div_active),
        .running    (running),
        .div_err    (div_err)
    );

    always #5 ref_clock = ~ref_clock;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Model: each period is a queue of samples; 2 = rise, 1 = high, 3 = fall, 0 = low.
    int m_q[$];
    int m_n, m_pval, m_h;
    bit m_pend, m_run, m_out, m_rise, m_fall, m_err;

    always @(posedge ref_clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_n = 10; m_pend = 0; m_pval = 10;
            m_run = 0; m_out = 0; m_rise = 0; m_fall = 0; m_err = 0;
        end else begin
            if (m_q.size() == 0) begin
                if (m_pend) begin
                    m_n = m_pval;
                    m_pend = 0;
                end
                if (enable) begin
                    m_h = (m_n + 1) / 2;
                    for (int i = 0; i < m_n; i++)
                        m_q.push_back(i == 0 ? 2 : (i < m_h ? 1 : (i == m_h ? 3 : 0)));
                    m_run = 1;
                end else begin
                    m_run = 0;
                end
            end
            m_out = 0; m_rise = 0; m_fall = 0; m_err = 0;
            if (m_q.size() > 0) begin
                int s;
                s = m_q.pop_front();
                m_out  = (s == 1 || s == 2);
                m_rise = (s == 2);
                m_fall = (s == 3);
            end
            if (div_load) begin
                if (div_in >= 2) begin
                    m_pval = int'(div_in);
                    m_pend = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // Per-cycle compare plus run-length / strobe-spacing measurement of the DUT waveform.
    int hi_len = 0, lo_len = 0, run_len = 0, rise_gap = 0, since_rise = 0, rise_count = 0;
    int err_count = 0;
    bit prev_out = 0;

    always @(negedge ref_clock) begin
        logic [12:0] got, exp;
        got = {clk_out, clk_rise, clk_fall, running, div_err, div_active};
        exp = {m_out, m_rise, m_fall, m_run, m_err, 8'(m_n)};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL cycle: got out/rise/fall/run/err=%b%b%b%b%b div=%0d, expected %b%b%b%b%b div=%0d (t=%0t)",
                      clk_out, clk_rise, clk_fall, running, div_err, div_active,
                      m_out, m_rise, m_fall, m_run, m_err, m_n, $time);
        if (clk_out == prev_out) run_len++;
        else begin
            if (prev_out) hi_len = run_len;
            else lo_len = run_len;
            run_len = 1;
        end
        prev_out = clk_out;
        if (clk_rise) begin
            rise_gap = since_rise;
            since_rise = 0;
            rise_count++;
        end
        since_rise++;
        if (div_err) err_count++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge ref_clock);
        #2;
    endtask

    task automatic wait_rise();
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1);
            seen = clk_rise;
        end
        check("wait_rise_timeout", int'(seen), 1);
    endtask

    task automatic load(input int v);
        div_in = 8'(v);
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    int rc, ec;

    initial begin
        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = '0;
        step(2);
        reset = 1'b0;
        step(2);
        check("reset_div_active", int'(div_active), 10);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_running", int'(running), 0);

        // Default divisor 10: first rise one edge after enable, 5/5 waveform.
        enable = 1'b1;
        step(1);
        check("start_rise", int'(clk_rise), 1);
        check("start_out", int'(clk_out), 1);
        step(40);
        check("div10_hi", hi_len, 5);
        check("div10_lo", lo_len, 5);
        check("div10_rise_gap", rise_gap, 10);

        // Stop at cnt = 6: period completes, then park without a new rise.
        wait_rise();
        step(6);
        enable = 1'b0;
        rc = rise_count;
        step(3);
        check("stop_still_running", int'(running), 1);
        step(1);
        check("stop_parked", int'(running), 0);
        step(16);
        check("stop_no_rise", rise_count - rc, 0);
        check("stop_out_low", int'(clk_out), 0);

        // Odd and minimum divisors loaded while parked.
        load(3);
        step(1);
        check("parked_load3", int'(div_active), 3);
        enable = 1'b1;
        step(12);
        check("div3_hi", hi_len, 2);
        check("div3_lo", lo_len, 1);
        enable = 1'b0;
        step(6);
        load(2);
        step(1);
        check("parked_load2", int'(div_active), 2);
        enable = 1'b1;
        step(10);
        check("div2_hi", hi_len, 1);
        check("div2_lo", lo_len, 1);

        // Back to 10, then drop and re-raise enable inside one period.
        load(10);
        step(12);
        wait_rise();
        step(3);
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(25);
        check("blip_running", int'(running), 1);
        check("blip_rise_gap", rise_gap, 10);
        check("blip_hi", hi_len, 5);

        // Mid-period change to 4 at cnt = 2.
        wait_rise();
        step(2);
        load(4);
        check("mid_not_yet", int'(div_active), 10);
        step(20);
        check("mid_div4", int'(div_active), 4);
        check("div4_hi", hi_len, 2);
        check("div4_lo", lo_len, 2);

        // Two loads in one period: the later one wins.
        wait_rise();
        div_in = 8'd6; div_load = 1'b1;
        step(1);
        div_in = 8'd7;
        step(1);
        div_load = 1'b0;
        check("two_loads_pending", int'(div_active), 4);
        step(30);
        check("two_loads_div7", int'(div_active), 7);
        check("div7_hi", hi_len, 4);
        check("div7_lo", lo_len, 3);

        // Illegal divisors: error pulse only, waveform unchanged.
        ec = err_count;
        load(0);
        check("err0_pulse", int'(div_err), 1);
        step(1);
        check("err0_single", int'(div_err), 0);
        load(1);
        check("err1_pulse", int'(div_err), 1);
        step(20);
        check("err_count", err_count - ec, 2);
        check("err_div_kept", int'(div_active), 7);
        check("err_hi", hi_len, 4);

        // Reset mid-run with 7 pending over an active 10.
        load(10);
        step(25);
        wait_rise();
        load(7);
        check("pre_reset_high", int'(clk_out), 1);
        reset = 1'b1;
        #1;
        check("async_reset_out", int'(clk_out), 0);
        step(2);
        reset = 1'b0;
        step(30);
        check("post_reset_div", int'(div_active), 10);
        check("post_reset_hi", hi_len, 5);
        check("post_reset_lo", lo_len, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
